// File: rtl/player_move.sv
// player_move: moves the player sprite one STEP per frame_tick using debounced
// buttons, clamped to the legal play area, and runs a timed chop action that
// freezes movement for CHOP_FRAMES frames.
// Optional feature: define PLAYER_DIAGONAL_MOVE_EN to let horizontal and
// vertical presses both move in the same frame (horizontal wins the facing).
// Without it only one axis moves per frame, priority left, right, up, down.
module player_move #(
    parameter int X_INIT      = 64,
    parameter int Y_INIT      = 64,
    parameter int STEP        = 2,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 1024,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 768,
    parameter int WIDTH       = 32,
    parameter int HEIGHT      = 32,
    parameter int CHOP_FRAMES = 60
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        chop_req,
    input  logic [3:0]  held_state,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic [1:0]  player_direction,
    output logic [3:0]  player_state,
    output logic        chop_done
);

    typedef enum logic {
        WALK = 1'b0,
        CHOP = 1'b1
    } state_t;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    // Position arithmetic is done in 12-bit signed so a step past zero goes
    // negative and clamps instead of wrapping around.
    localparam logic signed [11:0] STEP_S = 12'(STEP);
    localparam logic signed [11:0] X_LO   = 12'(X_MIN);
    localparam logic signed [11:0] X_HI   = 12'(X_MAX - WIDTH);
    localparam logic signed [11:0] Y_LO   = 12'(Y_MIN);
    localparam logic signed [11:0] Y_HI   = 12'(Y_MAX - HEIGHT);
    localparam logic [7:0]         CHOP_LAST = 8'(CHOP_FRAMES - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [10:0] x_reg, x_next;
    logic [9:0]  y_reg, y_next;
    logic [1:0]  dir_reg, dir_next;
    logic [3:0]  pstate_reg, pstate_next;
    logic        done_reg, done_next;

    // Effective presses after cancelling opposite buttons on each axis
    logic        press_l, press_r, press_u, press_d;
    logic        step_h, step_v, move_en;
    logic signed [11:0] x_wide, y_wide, x_cand, y_cand, x_clamp, y_clamp;

    function automatic logic signed [11:0] clamp12(
        input logic signed [11:0] v,
        input logic signed [11:0] lo,
        input logic signed [11:0] hi
    );
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    // State register and all registered outputs
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_reg  <= WALK;
            cnt_reg    <= 8'd0;
            x_reg      <= 11'(X_INIT);
            y_reg      <= 10'(Y_INIT);
            dir_reg    <= DIR_DOWN;
            pstate_reg <= 4'd0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            dir_reg    <= dir_next;
            pstate_reg <= pstate_next;
            done_reg   <= done_next;
        end
    end

    // Next-state logic: chop entry, frame counting and chop completion
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            WALK: begin
                // A chop request beats a same-cycle frame_tick
                if (chop_req) begin
                    state_next = CHOP;
                    cnt_next   = 8'd0;
                end
            end
            CHOP: begin
                // chop_req is ignored here so the counter is never restarted
                if (frame_tick) begin
                    if (cnt_reg == CHOP_LAST) begin
                        state_next = WALK;
                        cnt_next   = 8'd0;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end
            end
            default: begin
                state_next = WALK;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // Output logic: movement, clamping, facing and player_state
    always_comb begin
        press_l = btn_left  & ~btn_right;
        press_r = btn_right & ~btn_left;
        press_u = btn_up    & ~btn_down;
        press_d = btn_down  & ~btn_up;

`ifdef PLAYER_DIAGONAL_MOVE_EN
        step_h = press_l | press_r;
        step_v = press_u | press_d;
`else
        step_h = press_l | press_r;
        step_v = ~step_h & (press_u | press_d);
`endif

        move_en = (state_reg == WALK) && frame_tick && !chop_req;

        x_wide  = $signed({1'b0, x_reg});
        y_wide  = $signed({2'b00, y_reg});
        x_cand  = press_l ? (x_wide - STEP_S) : (x_wide + STEP_S);
        y_cand  = press_u ? (y_wide - STEP_S) : (y_wide + STEP_S);
        x_clamp = clamp12(x_cand, X_LO, X_HI);
        y_clamp = clamp12(y_cand, Y_LO, Y_HI);

        x_next   = x_reg;
        y_next   = y_reg;
        dir_next = dir_reg;
        if (move_en) begin
            // Vertical first so a horizontal move overrides the facing.
            // A blocked move still turns the sprite toward the bound.
            if (step_v) begin
                y_next   = 10'(y_clamp);
                dir_next = press_u ? DIR_UP : DIR_DOWN;
            end
            if (step_h) begin
                x_next   = 11'(x_clamp);
                dir_next = press_l ? DIR_LEFT : DIR_RIGHT;
            end
        end

        pstate_next = (state_next == CHOP) ? 4'd1 : held_state;
    end

    assign x_out            = x_reg;
    assign y_out            = y_reg;
    assign player_direction = dir_reg;
    assign player_state     = pstate_reg;
    assign chop_done        = done_reg;

endmodule
